// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op bit positions,
// FSM states, decoded op kinds and the priority decoder for in_op.
package mdu_sched_pkg;

  localparam int MDU_OP_WD = 8;
  localparam int MDU_MULT  = 0;
  localparam int MDU_MULTU = 1;
  localparam int MDU_DIV   = 2;
  localparam int MDU_DIVU  = 3;
  localparam int MDU_MTHI  = 4;
  localparam int MDU_MTLO  = 5;
  localparam int MDU_MFHI  = 6;
  localparam int MDU_MFLO  = 7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  typedef enum logic [3:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
  } op_e;

  // Multi-hot encodings resolve to the lowest set bit; all-zero is a no-op.
  function automatic op_e op_decode(logic [MDU_OP_WD-1:0] op);
    if      (op[MDU_MULT])  return OP_MULT;
    else if (op[MDU_MULTU]) return OP_MULTU;
    else if (op[MDU_DIV])   return OP_DIV;
    else if (op[MDU_DIVU])  return OP_DIVU;
    else if (op[MDU_MTHI])  return OP_MTHI;
    else if (op[MDU_MTLO])  return OP_MTLO;
    else if (op[MDU_MFHI])  return OP_MFHI;
    else if (op[MDU_MFLO])  return OP_MFLO;
    else                    return OP_NONE;
  endfunction

  // Sign- or zero-extend a 32-bit operand to 64 bits for the multiplier.
  function automatic logic [63:0] ext64(logic [31:0] x, logic sgn);
    return {{32{sgn & x[31]}}, x};
  endfunction

endpackage

// File: rtl/mdu_sched_div_iter.sv
// Unsigned 32-bit radix-2 restoring divider, one quotient bit per cycle.
// The quotient register doubles as the dividend shift register.
module div_iter #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clr,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int CW = $clog2(ITER + 1);

  logic [31:0]   dsr;
  logic [CW-1:0] cnt;
  logic          run;
  logic [32:0]   sh;
  logic          ge;
  logic [31:0]   rem_nxt;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    sh      = {rem, quot[31]};
    ge      = (sh >= {1'b0, dsr});
    rem_nxt = ge ? 32'(sh - {1'b0, dsr}) : sh[31:0];
  end

  // Load on start, then shift one quotient bit in per cycle until ITER steps are done.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      rem  <= '0;
      quot <= '0;
      dsr  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      quot <= dividend;
      dsr  <= divisor;
      cnt  <= CW'(ITER);
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      rem  <= rem_nxt;
      quot <= {quot[30:0], ge};
      cnt  <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: owns HI/LO, sequences a fixed-latency multiply
// and an iterative divide, and stalls EXE (in_ready low) while one is in flight.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic        cancel,
  output logic        in_ready,
  output logic [31:0] mf_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (DIV_ITER > MUL_LAT) ? DIV_ITER : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [63:0]   prod;
  logic          q_neg, r_neg, dz;
  logic [31:0]   dvd_raw;
  op_e           op;
  logic          accept, acc_mul, acc_div, sgn;
  logic [31:0]   abs1, abs2;
  logic          mul_done, fix_done;
  logic          div_done;
  logic [31:0]   div_q, div_r;

  assign op      = op_decode(in_op);
  assign accept  = in_valid & in_ready;
  assign acc_mul = accept & ((op == OP_MULT) | (op == OP_MULTU));
  assign acc_div = accept & ((op == OP_DIV)  | (op == OP_DIVU));
  assign sgn     = (op == OP_MULT) | (op == OP_DIV);
  assign abs1    = (sgn && in_src1[31]) ? -in_src1 : in_src1;
  assign abs2    = (sgn && in_src2[31]) ? -in_src2 : in_src2;
  assign mf_data = in_op[MDU_MFHI] ? hi : lo;
  assign busy    = (state != S_IDLE);

  div_iter #(.ITER(DIV_ITER)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (acc_div),
    .clr      (cancel),
    .dividend (abs1),
    .divisor  (abs2),
    .done     (div_done),
    .quot     (div_q),
    .rem      (div_r)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, handshake and completion strobes; cancel beats completion.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_done  = 1'b0;
    fix_done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = ~cancel;
        if (acc_mul)      state_nxt = S_MUL;
        else if (acc_div) state_nxt = S_DIV;
      end
      S_MUL: begin
        if (cancel) state_nxt = S_IDLE;
        else if (cnt == '0) begin
          mul_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DIV: begin
        if (cancel)           state_nxt = S_IDLE;
        else if (cnt == '0)   state_nxt = S_FIX;
      end
      S_FIX: begin
        fix_done  = ~cancel & div_done;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, latency counter and HI/LO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      prod    <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz      <= 1'b0;
      dvd_raw <= '0;
    end else begin
      if ((state == S_MUL || state == S_DIV) && cnt != '0) cnt <= cnt - 1'b1;
      if (acc_mul) begin
        prod <= ext64(in_src1, sgn) * ext64(in_src2, sgn);
        cnt  <= CW'(MUL_LAT - 1);
      end
      if (acc_div) begin
        q_neg   <= sgn & (in_src1[31] ^ in_src2[31]);
        r_neg   <= sgn & in_src1[31];
        dz      <= (in_src2 == '0);
        dvd_raw <= in_src1;
        cnt     <= CW'(DIV_ITER - 1);
      end
      if (accept && op == OP_MTHI) hi <= in_src1;
      if (accept && op == OP_MTLO) lo <= in_src1;
      if (mul_done) {hi, lo} <= prod;
      if (fix_done) begin
        if (dz) begin
          hi <= dvd_raw;
          lo <= 32'hFFFF_FFFF;
        end else begin
          hi <= r_neg ? -div_r : div_r;
          lo <= q_neg ? -div_q : div_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed and random checks of mdu_sched against an arithmetic model of HI/LO.
module tb_mdu_sched;

  localparam int MUL_LAT  = 2;
  localparam int DIV_ITER = 32;
  localparam int BOUND    = 200;

  localparam logic [7:0] OP_MULT  = 8'h01;
  localparam logic [7:0] OP_MULTU = 8'h02;
  localparam logic [7:0] OP_DIV   = 8'h04;
  localparam logic [7:0] OP_DIVU  = 8'h08;
  localparam logic [7:0] OP_MTHI  = 8'h10;
  localparam logic [7:0] OP_MTLO  = 8'h20;
  localparam logic [7:0] OP_MFHI  = 8'h40;
  localparam logic [7:0] OP_MFLO  = 8'h80;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_op = '0;
  logic [31:0] in_src1 = '0;
  logic [31:0] in_src2 = '0;
  logic        cancel = 1'b0;
  logic        in_ready, busy;
  logic [31:0] mf_data, hi, lo;

  int errs = 0;
  int checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_sched #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .cancel(cancel),
    .in_ready(in_ready), .mf_data(mf_data), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural effect of an op on HI/LO, from the arithmetic rules.
  task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_DIV, OP_DIVU: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else begin
          if (op == OP_DIVU) begin sa = longint'({32'b0, a}); sb = longint'({32'b0, b}); end
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_stall(input logic [7:0] op);
    if (op == OP_MULT || op == OP_MULTU) return MUL_LAT;
    if (op == OP_DIV || op == OP_DIVU)   return DIV_ITER + 1;
    return 0;
  endfunction

  // Called at posedge+2 in a cycle: present op, wait for accept, count stall cycles.
  // Returns in the first ready cycle afterwards (again at posedge+2).
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stall);
    int g;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
    g = 0;
    #1;
    while (!in_ready && g < BOUND) begin @(posedge clk); #2; g++; end
    if (g >= BOUND) check("accept_timeout", 64'(g), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = '0;
    model(op, a, b);
    stall = 0;
    #1;
    while (!in_ready && stall < BOUND) begin @(posedge clk); #2; stall++; end
  endtask

  task automatic run_check(input string tag, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    int st;
    issue(op, a, b, st);
    check({tag, "_stall"}, 64'(st), 64'(exp_stall(op)));
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 64));
      5: return -32'($urandom_range(1, 64));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [7:0] ops [6];
    logic [7:0] op;
    logic [31:0] a, b;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_ready", 64'(in_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_mf", 64'(mf_data), 64'(0));

    run_check("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo_const", 64'(lo), 64'h0000_0000_0000_0001);
    run_check("mult_neg", OP_MULT, -32'd3, 32'd5);
    check("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFF1);
    run_check("div_neg", OP_DIV, -32'd7, 32'd2);
    check("div_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    run_check("divu_zero", OP_DIVU, 32'd100, 32'd0);
    check("divu_zero_hi_const", 64'(hi), 64'h0000_0000_0000_0064);
    run_check("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", 64'(lo), 64'h0000_0000_8000_0000);
    run_check("div_zero", OP_DIV, -32'd9, 32'd0);

    // mfhi held behind a divide: accepted only once IDLE, sees the new hi.
    in_valid = 1'b1; in_op = OP_DIV; in_src1 = 32'd1000; in_src2 = -32'd7;
    #1;
    check("mfhold_first_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    model(OP_DIV, 32'd1000, -32'd7);
    in_op = OP_MFHI; in_src1 = '0; in_src2 = '0;
    n = 0;
    #1;
    while (!in_ready && n < BOUND) begin @(posedge clk); #2; n++; end
    check("mfhold_stall", 64'(n), 64'(DIV_ITER + 1));
    check("mfhold_data", 64'(mf_data), 64'(m_hi));
    @(posedge clk); #1 in_valid = 1'b0; in_op = '0; #1;

    // mthi then mfhi / mflo in the following cycles.
    run_check("mthi", OP_MTHI, 32'h1234, 32'h0);
    in_op = OP_MFHI; #1;
    check("mfhi_after_mthi", 64'(mf_data), 64'h1234);
    in_op = OP_MFLO; #1;
    check("mflo", 64'(mf_data), 64'(m_lo));
    in_op = '0; #1;
    check("mf_default_lo", 64'(mf_data), 64'(m_lo));

    // Cancel during the 10th divide iteration: hi/lo unchanged.
    @(posedge clk); #2;
    in_valid = 1'b1; in_op = OP_DIVU; in_src1 = 32'd77; in_src2 = 32'd5;
    @(posedge clk); #1 in_valid = 1'b0; in_op = '0;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0; #1;
    check("cancel_ready", 64'(in_ready), 64'(1));
    check("cancel_busy", 64'(busy), 64'(0));
    check("cancel_hi", 64'(hi), 64'(m_hi));
    check("cancel_lo", 64'(lo), 64'(m_lo));

    // Cancel in IDLE blocks acceptance.
    cancel = 1'b1; #1;
    check("cancel_idle_ready", 64'(in_ready), 64'(0));
    cancel = 1'b0; #1;

    // Reset mid-divide, together with cancel: reset wins.
    @(posedge clk); #2;
    in_valid = 1'b1; in_op = OP_DIV; in_src1 = 32'd500; in_src2 = 32'd3;
    @(posedge clk); #1 in_valid = 1'b0; in_op = '0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1; cancel = 1'b1;
    @(posedge clk); #1 reset = 1'b0; cancel = 1'b0; #1;
    m_hi = '0; m_lo = '0;
    check("rstmid_hi", 64'(hi), 64'(0));
    check("rstmid_lo", 64'(lo), 64'(0));
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_ready", 64'(in_ready), 64'(1));

    // Random back-to-back ops against the model.
    for (int i = 0; i < 2000; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = pick();
      b = pick();
      run_check("rand", op, a, b);
      if ($urandom_range(0, 7) == 0) begin
        in_op = OP_MFHI; #1;
        check("rand_mfhi", 64'(mf_data), 64'(m_hi));
        in_op = OP_MFLO; #1;
        check("rand_mflo", 64'(mf_data), 64'(m_lo));
        in_op = '0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
